// File: rtl/stfwd_if.sv
// Store-forward downstream port between the load-pipe arbiter and storeQue/sbuffer.
// Latency: none; plain wires. s0 request, s1 physical check, s2 response.
// Backpressure: s2 response is qualified by fwd_s2_rdy from the slave side.
interface stfwd_if #(
  parameter int XLEN    = 64,
  parameter int LQ_W    = 6,
  parameter int SQ_W    = 6,
  parameter int PADDR_W = 36
);
  // s0: forward request
  logic                 fwd_s0_vld;
  logic [LQ_W-1:0]      fwd_s0_lqIdx;
  logic [SQ_W-1:0]      fwd_s0_sqIdx;
  logic [XLEN-1:0]      fwd_s0_vaddr;
  logic [XLEN/8-1:0]    fwd_s0_load_vec;
  // s1: physical address check
  logic                 fwd_s1_vld;
  logic [PADDR_W-1:0]   fwd_s1_paddr;
  logic                 fwd_s1_vaddr_match;
  logic                 fwd_s1_data_rdy;
  // s2: response payload
  logic                 fwd_s2_rdy;
  logic [LQ_W-1:0]      fwd_s2_lqIdx;
  logic                 fwd_s2_paddr_match;
  logic                 fwd_s2_match_failed;
  logic [XLEN/8-1:0]    fwd_s2_match_vec;
  logic [XLEN-1:0]      fwd_s2_fwd_data;

  modport master (
    output fwd_s0_vld, fwd_s0_lqIdx, fwd_s0_sqIdx, fwd_s0_vaddr, fwd_s0_load_vec,
    output fwd_s1_vld, fwd_s1_paddr,
    input  fwd_s1_vaddr_match, fwd_s1_data_rdy,
    input  fwd_s2_rdy, fwd_s2_lqIdx, fwd_s2_paddr_match, fwd_s2_match_failed,
    input  fwd_s2_match_vec, fwd_s2_fwd_data
  );

  modport slave (
    input  fwd_s0_vld, fwd_s0_lqIdx, fwd_s0_sqIdx, fwd_s0_vaddr, fwd_s0_load_vec,
    input  fwd_s1_vld, fwd_s1_paddr,
    output fwd_s1_vaddr_match, fwd_s1_data_rdy,
    output fwd_s2_rdy, fwd_s2_lqIdx, fwd_s2_paddr_match, fwd_s2_match_failed,
    output fwd_s2_match_vec, fwd_s2_fwd_data
  );
endinterface

// File: rtl/stfwd_arbiter.sv
// Shares one store-forward port among NUM_REQ load pipes; tracks the owner through s1/s2.
// Latency: s0 grant combinational; s0->s1 1 cycle, s1->s2 1 cycle; s2 results routed to owner.
// Backpressure: ungranted s0 pipes replay; s2 response waits on fwd_s2_rdy. Macro STFWD_ARB_RR_EN
// selects round-robin arbitration; without it the lowest index wins.
module stfwd_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int OWNER_W = 2,
  parameter int XLEN    = 64,
  parameter int LQ_W    = 6,
  parameter int SQ_W    = 6,
  parameter int PADDR_W = 36
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  // s0 requests
  input  logic [NUM_REQ-1:0]  req_s0_vld,
  input  logic [LQ_W-1:0]     req_s0_lqIdx    [NUM_REQ],
  input  logic [SQ_W-1:0]     req_s0_sqIdx    [NUM_REQ],
  input  logic [XLEN-1:0]     req_s0_vaddr    [NUM_REQ],
  input  logic [XLEN/8-1:0]   req_s0_load_vec [NUM_REQ],
  output logic [NUM_REQ-1:0]  req_s0_gnt,
  // s1 checks
  input  logic [NUM_REQ-1:0]  req_s1_vld,
  input  logic [PADDR_W-1:0]  req_s1_paddr    [NUM_REQ],
  output logic [NUM_REQ-1:0]  req_s1_vaddr_match,
  output logic [NUM_REQ-1:0]  req_s1_data_rdy,
  // s2 responses
  output logic [NUM_REQ-1:0]  req_s2_rdy,
  output logic [LQ_W-1:0]     req_s2_lqIdx,
  output logic                req_s2_paddr_match,
  output logic                req_s2_match_failed,
  output logic [XLEN/8-1:0]   req_s2_match_vec,
  output logic [XLEN-1:0]     req_s2_fwd_data,
  // downstream port
  stfwd_if.master             fwd
);

  logic [NUM_REQ-1:0]  s0_gnt;
  logic [OWNER_W-1:0]  s0_win;
  logic                s0_found;

  logic                s1_vld_q;
  logic [OWNER_W-1:0]  s1_owner;
  logic                s1_req_vld;
  logic [PADDR_W-1:0]  s1_paddr;
  logic                s1_live;

  logic                s2_vld_q;
  logic [OWNER_W-1:0]  s2_owner;

`ifdef STFWD_ARB_RR_EN
  logic [OWNER_W-1:0]  rr_ptr;
`endif

  // s0 arbitration: optional first pass from the RR pointer upward, then a wrap pass from 0
  always_comb begin
    s0_gnt   = '0;
    s0_win   = '0;
    s0_found = 1'b0;
`ifdef STFWD_ARB_RR_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!s0_found && req_s0_vld[i] && (OWNER_W'(i) >= rr_ptr)) begin
        s0_found = 1'b1;
        s0_win   = OWNER_W'(i);
      end
    end
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!s0_found && req_s0_vld[i]) begin
        s0_found = 1'b1;
        s0_win   = OWNER_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      s0_gnt[i] = s0_found && !rst && (s0_win == OWNER_W'(i));
    end
  end

  assign req_s0_gnt = s0_gnt;

  // s0 payload mux: granted pipe's fields, all zero when nobody is granted
  always_comb begin
    fwd.fwd_s0_vld      = |s0_gnt;
    fwd.fwd_s0_lqIdx    = '0;
    fwd.fwd_s0_sqIdx    = '0;
    fwd.fwd_s0_vaddr    = '0;
    fwd.fwd_s0_load_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (s0_gnt[i]) begin
        fwd.fwd_s0_lqIdx    = req_s0_lqIdx[i];
        fwd.fwd_s0_sqIdx    = req_s0_sqIdx[i];
        fwd.fwd_s0_vaddr    = req_s0_vaddr[i];
        fwd.fwd_s0_load_vec = req_s0_load_vec[i];
      end
    end
  end

  // s1 owner select: the owning pipe's s1 valid and physical address
  always_comb begin
    s1_req_vld = 1'b0;
    s1_paddr   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (s1_owner == OWNER_W'(i)) begin
        s1_req_vld = req_s1_vld[i];
        s1_paddr   = req_s1_paddr[i];
      end
    end
  end

  // A slot survives s1 only if the owner still holds its request and no squash is in progress
  assign s1_live          = s1_vld_q && s1_req_vld && !flush;
  assign fwd.fwd_s1_vld   = s1_live;
  assign fwd.fwd_s1_paddr = s1_paddr;

  // s1 and s2 results steered to the owning pipe only
  always_comb begin
    req_s1_vaddr_match = '0;
    req_s1_data_rdy    = '0;
    req_s2_rdy         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (s1_vld_q && (s1_owner == OWNER_W'(i))) begin
        req_s1_vaddr_match[i] = fwd.fwd_s1_vaddr_match;
        req_s1_data_rdy[i]    = fwd.fwd_s1_data_rdy;
      end
      if (s2_vld_q && (s2_owner == OWNER_W'(i))) begin
        req_s2_rdy[i] = fwd.fwd_s2_rdy;
      end
    end
  end

  // s2 payload is broadcast; req_s2_rdy tells the owner it is meant for it
  assign req_s2_lqIdx        = fwd.fwd_s2_lqIdx;
  assign req_s2_paddr_match  = fwd.fwd_s2_paddr_match;
  assign req_s2_match_failed = fwd.fwd_s2_match_failed;
  assign req_s2_match_vec    = fwd.fwd_s2_match_vec;
  assign req_s2_fwd_data     = fwd.fwd_s2_fwd_data;

  // Owner pipeline: s0 grant -> s1 -> s2; reset discards anything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_owner <= '0;
      s2_vld_q <= 1'b0;
      s2_owner <= '0;
    end else begin
      s1_vld_q <= |s0_gnt;
      s1_owner <= s0_win;
      s2_vld_q <= s1_live;
      s2_owner <= s1_owner;
    end
  end

`ifdef STFWD_ARB_RR_EN
  // Round-robin pointer moves just past the winner on every grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (|s0_gnt) begin
      rr_ptr <= (s0_win == OWNER_W'(NUM_REQ - 1)) ? '0 : s0_win + OWNER_W'(1);
    end
  end
`endif

endmodule

// File: doc/stfwd_arbiter.md
STFWD_ARBITER -- requirements
Module: stfwd_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of load pipes sharing one store-forward port; legal range 2..4.
REQ-002 Parameter OWNER_W, default 2: owner-index width; SHALL be at least clog2(NUM_REQ).
REQ-003 Ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state on rising edge.
  rst  in  1  asynchronous, active-high reset.
  flush  in  1  pipeline squash; kills in-flight s1 owner.
  req_s0_vld  in  NUM_REQ  per-pipe s0 forward request.
  req_s0_lqIdx  in  NUM_REQ x lqIdx_t  per-pipe load queue index.
  req_s0_sqIdx  in  NUM_REQ x sqIdx_t  per-pipe store age bound.
  req_s0_vaddr  in  NUM_REQ x XLEN  per-pipe virtual address.
  req_s0_load_vec  in  NUM_REQ x XLEN/8  per-pipe byte mask.
  req_s0_gnt  out  NUM_REQ  one-hot s0 grant; ungranted pipe replays.
  req_s1_vld, req_s1_paddr  in  NUM_REQ, NUM_REQ x paddr_t  per-pipe s1 check.
  req_s1_vaddr_match, req_s1_data_rdy  out  NUM_REQ each  s1 results routed to owner.
  req_s2_rdy  out  NUM_REQ  s2 response valid, owner only.
  req_s2_lqIdx, req_s2_paddr_match, req_s2_match_failed, req_s2_match_vec, req_s2_fwd_data  out  shared  s2 payload broadcast; qualified by req_s2_rdy.
  fwd_*  m-side  per stfwd_if  single downstream port to storeQue/sbuffer.

Function
REQ-004 s0: arbiter SHALL select at most one valid requester per cycle; req_s0_gnt one-hot or zero, combinational from req_s0_vld and pointer.
REQ-005 fwd_s0_vld SHALL equal OR of req_s0_gnt; fwd_s0 payload SHALL be the granted pipe's fields, zero when none.
REQ-006 Owner pipeline: s1_owner/s1_vld_q registered from s0 grant; s2_owner/s2_vld_q registered from s1 stage; latency s0->s1 = 1 cycle, s1->s2 = 1 cycle.
REQ-007 fwd_s1_vld SHALL equal s1_vld_q AND req_s1_vld[s1_owner] AND NOT flush; fwd_s1_paddr SHALL be req_s1_paddr[s1_owner].
REQ-008 req_s1_vaddr_match/data_rdy SHALL be driven only at bit s1_owner when s1_vld_q, else 0.
REQ-009 req_s2_rdy[s2_owner] SHALL equal fwd_s2_rdy AND s2_vld_q; other bits 0; s2 payload passed through unmodified.
REQ-010 s2_vld_q SHALL load s1_vld_q AND req_s1_vld[s1_owner] AND NOT flush.
REQ-011 If owner drops req_s1_vld in s1, the s1 slot SHALL be dropped: no fwd_s1_vld, no s2 response.
REQ-012 fwd_s2_rdy without s2_vld_q SHALL be ignored (no req_s2_rdy asserted).
REQ-013 flush SHALL clear s1_vld_q effect same cycle and s0 grants that cycle SHALL still advance to s1 (new requests post-flush are valid).
REQ-014 A pipe may win s0 while it still owns s1 or s2; back-to-back grants to one pipe SHALL be legal.

Reset
REQ-015 On rst: s1_vld_q=0, s2_vld_q=0, owners=0, RR pointer=0; all req_* outputs and fwd_s0_vld/fwd_s1_vld SHALL be 0 while rst asserted.
REQ-016 Reset mid-transaction SHALL discard in-flight s1/s2 ownership; no response delivered after release for pre-reset requests.

Configuration
REQ-017 Macro STFWD_ARB_RR_EN defined: round-robin; pointer advances to (winner+1) mod NUM_REQ on any grant; search starts at pointer.
REQ-018 Macro absent: fixed priority, lowest index wins; pointer register not instantiated.

Verification
REQ-019 Pipes 0,1 both s0_vld, RR on, pointer 0 -> gnt=01 cycle 0; repeat -> gnt=10 cycle 1; RR off -> gnt=01 both cycles.
REQ-020 Pipe 1 alone granted cycle 0, req_s1_vld[1]=1 cycle 1, fwd_s2_rdy=1 cycle 2 -> req_s2_rdy=10 cycle 2, req_s2_rdy[0]=0.
REQ-021 Grant pipe 0 cycle 0, flush=1 cycle 1 -> fwd_s1_vld=0 cycle 1, req_s2_rdy=00 cycle 2.
REQ-022 Pipe 0 granted, req_s1_vld[0]=0 cycle 1 -> fwd_s1_vld=0, no req_s2_rdy cycle 2.
REQ-023 Pipe 0 granted 3 consecutive cycles, fwd_s2_rdy always 1 -> req_s2_rdy=01 cycles 2,3,4, fwd_s1_vaddr_match routed only to bit 0.
REQ-024 rst asserted during cycle 1 of REQ-020 sequence -> all outputs 0, no req_s2_rdy after release.
